// File: rtl/csa_sub_pipe.sv
// ============================================================================
//  Module   : csa_sub_pipe
//  Function : Pipelined carry-select subtractor, diff = a + ~b + 1, one
//             4-bit carry-select segment per stage, valid/ready handshake.
//             Optional macro CSA_SUB_SAT_EN clamps o_diff on signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_sub_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sub_term1,
    input  logic [WIDTH-1:0] i_sub_term2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);

    localparam int SEG = WIDTH / 4;

    logic             w_adv;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_diff;
    logic             r_out_borrow;
    logic             r_out_ovf;

    // A single enable for the whole pipe keeps bubbles in place under stall.
    assign w_adv   = !r_out_vld || i_ready;
    assign o_ready = w_adv;

    // Stages 0..SEG-2: one segment each, unprocessed upper operand bits skewed along.
    genvar k;
    generate
        for (k = 0; k < SEG - 1; k++) begin : g_stage
            localparam int HW = WIDTH - 4 * (k + 1);

            logic [3:0]     w_a_seg;
            logic [3:0]     w_b_seg;
            logic [HW-1:0]  w_a_rest;
            logic [HW-1:0]  w_b_rest;
            logic           w_cin;
            logic           w_vin;
            logic [4:0]     w_sum0;
            logic [4:0]     w_sum1;
            logic [4:0]     w_sel;
            logic [4*k+3:0] w_d_next;

            logic           r_v;
            logic           r_c;
            logic [4*k+3:0] r_d;
            logic [HW-1:0]  r_a_hi;
            logic [HW-1:0]  r_b_hi;

            if (k == 0) begin : g_first
                assign w_a_seg  = i_sub_term1[3:0];
                assign w_b_seg  = i_sub_term2[3:0];
                assign w_a_rest = i_sub_term1[WIDTH-1:4];
                assign w_b_rest = i_sub_term2[WIDTH-1:4];
                assign w_cin    = 1'b1;
                assign w_vin    = i_valid;
                assign w_d_next = w_sel[3:0];
            end else begin : g_next
                assign w_a_seg  = g_stage[k-1].r_a_hi[3:0];
                assign w_b_seg  = g_stage[k-1].r_b_hi[3:0];
                assign w_a_rest = g_stage[k-1].r_a_hi[HW+3:4];
                assign w_b_rest = g_stage[k-1].r_b_hi[HW+3:4];
                assign w_cin    = g_stage[k-1].r_c;
                assign w_vin    = g_stage[k-1].r_v;
                assign w_d_next = {w_sel[3:0], g_stage[k-1].r_d};
            end

            assign w_sum0 = {1'b0, w_a_seg} + {1'b0, ~w_b_seg};
            assign w_sum1 = {1'b0, w_a_seg} + {1'b0, ~w_b_seg} + 5'd1;
            assign w_sel  = w_cin ? w_sum1 : w_sum0;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_v    <= 1'b0;
                    r_c    <= 1'b0;
                    r_d    <= '0;
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_adv) begin
                    r_v    <= w_vin;
                    r_c    <= w_sel[4];
                    r_d    <= w_d_next;
                    r_a_hi <= w_a_rest;
                    r_b_hi <= w_b_rest;
                end
            end
        end
    endgenerate

    // Final segment: also derives the flags and the optional clamp before registering.
    logic [3:0]       w_a_top;
    logic [3:0]       w_b_top;
    logic [4:0]       w_top0;
    logic [4:0]       w_top1;
    logic [4:0]       w_top_sel;
    logic [WIDTH-1:0] w_diff_raw;
    logic [WIDTH-1:0] w_diff_fin;
    logic             w_ovf;

    assign w_a_top    = g_stage[SEG-2].r_a_hi;
    assign w_b_top    = g_stage[SEG-2].r_b_hi;
    assign w_top0     = {1'b0, w_a_top} + {1'b0, ~w_b_top};
    assign w_top1     = {1'b0, w_a_top} + {1'b0, ~w_b_top} + 5'd1;
    assign w_top_sel  = g_stage[SEG-2].r_c ? w_top1 : w_top0;
    assign w_diff_raw = {w_top_sel[3:0], g_stage[SEG-2].r_d};
    assign w_ovf      = (w_a_top[3] != w_b_top[3]) && (w_diff_raw[WIDTH-1] != w_a_top[3]);

`ifdef CSA_SUB_SAT_EN
    localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_diff_fin = !w_ovf ? w_diff_raw : (w_a_top[3] ? C_MAX_NEG : C_MAX_POS);
`else
    assign w_diff_fin = w_diff_raw;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_vld    <= 1'b0;
            r_out_diff   <= '0;
            r_out_borrow <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else if (w_adv) begin
            r_out_vld    <= g_stage[SEG-2].r_v;
            r_out_diff   <= w_diff_fin;
            r_out_borrow <= ~w_top_sel[4];
            r_out_ovf    <= w_ovf;
        end
    end

    assign o_valid  = r_out_vld;
    assign o_diff   = r_out_diff;
    assign o_borrow = r_out_borrow;
    assign o_ovf    = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_csa_sub_pipe.sv
// ============================================================================
//  Module   : tb_csa_sub_pipe
//  Function : Randomized and directed bench for csa_sub_pipe against an
//             integer-arithmetic reference model (honours CSA_SUB_SAT_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csa_sub_pipe;

    localparam int W   = 12;
    localparam int SEG = W / 4;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_sub_term1;
    logic [W-1:0] i_sub_term2;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_ovf;

    csa_sub_pipe #(.WIDTH(W)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sub_term1 (i_sub_term1),
        .i_sub_term2 (i_sub_term2),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_diff      (o_diff),
        .o_borrow    (o_borrow),
        .o_ovf       (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cyc;
        int           st;
    } op_t;

    op_t q[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  stalls = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (2 ** W) : int'(v);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = to_signed(a) - to_signed(b);
        return (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        d = (int'(a) - int'(b) + 2 ** W) % (2 ** W);
`ifdef CSA_SUB_SAT_EN
        if (ref_ovf(a, b))
            d = (to_signed(a) - to_signed(b) > 0) ? 2 ** (W - 1) - 1 : 2 ** (W - 1);
`endif
        return W'(d);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_valid && !i_ready) stalls <= stalls + 1;
    end

    // Scoreboard: record accepted inputs, compare every visible result with the model.
    always @(negedge clk) begin
        if (i_rst_n) begin
            if (i_valid && o_ready) q.push_back('{a: i_sub_term1, b: i_sub_term2, cyc: cyc, st: stalls});
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk_eq("stale_result", 32'(o_valid), 32'd0);
                end else begin
                    chk_eq("diff",   32'(o_diff),   32'(ref_diff(q[0].a, q[0].b)));
                    chk_eq("borrow", 32'(o_borrow), 32'(q[0].a < q[0].b));
                    chk_eq("ovf",    32'(o_ovf),    32'(ref_ovf(q[0].a, q[0].b)));
                    if (i_ready) begin
                        chk_eq("latency", 32'(cyc - q[0].cyc), 32'(SEG + stalls - q[0].st));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        i_valid     = 1'b1;
        i_sub_term1 = a;
        i_sub_term2 = b;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk_eq("send_timeout", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk_eq("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_sub_term1 = '0;
        i_sub_term2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_valid",  32'(o_valid),  32'd0);
        chk_eq("rst_ready",  32'(o_ready),  32'd1);
        chk_eq("rst_diff",   32'(o_diff),   32'd0);
        chk_eq("rst_borrow", 32'(o_borrow), 32'd0);
        chk_eq("rst_ovf",    32'(o_ovf),    32'd0);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed boundary cases
        send(12'h9C4, 12'h1A7);
        drain();
        send(12'h000, 12'h001);
        send(12'h800, 12'h001);
        send(12'h7FF, 12'h800);
        send(12'h5A5, 12'h5A5);
        send(12'hFFF, 12'h000);
        drain();

        // Back-to-back random stream
        for (int i = 0; i < 20; i++) send(W'($urandom), W'($urandom));
        drain();

        // Backpressure: 3 ops in flight, consumer stalls 5 cycles, one more op waits
        send(W'($urandom), W'($urandom));
        send(W'($urandom), W'($urandom));
        send(W'($urandom), W'($urandom));
        i_ready     = 1'b0;
        i_valid     = 1'b1;
        i_sub_term1 = W'($urandom);
        i_sub_term2 = W'($urandom);
        repeat (5) begin
            @(negedge clk);
            chk_eq("stall_ready", 32'(o_ready), 32'd0);
            chk_eq("stall_valid", 32'(o_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        drain();

        // Asynchronous reset with two ops in flight
        send(12'h123, 12'h045);
        @(posedge clk);
        #1;
        send(12'h456, 12'h789);
        chk_eq("pre_rst_valid", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk_eq("async_rst_valid", 32'(o_valid), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk_eq("post_rst_valid", 32'(o_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(12'h800, 12'h7FF);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csa_sub_pipe.md
Name: csa_sub_pipe

Overview:
- Pipelined carry-select subtractor, the inverse operation of the team's 12-bit carry-select adder.
- Computes o_diff = i_sub_term1 - i_sub_term2 as i_sub_term1 + ~i_sub_term2 + 1.
- Uses one 4-bit carry-select segment per pipeline stage, so the carry chain is cut at every segment boundary.
- Sits in the arithmetic datapath behind a valid/ready handshake, with backpressure from the consumer.

Parameters:
- WIDTH, 12: operand width; must be a multiple of 4 and at least 8.
- SEG, WIDTH/4 (derived, localparam): number of segments, which equals the pipeline depth.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands this cycle.
- i_sub_term1  input  WIDTH  minuend.
- i_sub_term2  input  WIDTH  subtrahend.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_diff  output  WIDTH  difference, modulo 2^WIDTH.
- o_borrow  output  1  unsigned borrow; 1 when i_sub_term1 < i_sub_term2.
- o_ovf  output  1  signed (two's complement) overflow.

Behaviour:
- Reset, asynchronous on i_rst_n low: all stage valid bits cleared; o_valid=0, o_diff=0, o_borrow=0, o_ovf=0. o_ready=1 during and after reset.
- Global advance enable: adv = !o_valid || i_ready. o_ready = adv, combinational.
- Transfer in when i_valid && o_ready. Transfer out when o_valid && i_ready.
- When adv=0, every stage holds its data and valid bit; nothing is lost or duplicated.
- Bubbles are not compressed. An empty stage still advances only with adv.
- Stage k (k=0..SEG-1) processes bits [4k+3:4k]:
  - For each of carry-in 0 and carry-in 1, computes the 4-bit sum of A and ~B plus the carry.
  - Selects one result using the carry registered out of stage k-1. Stage 0 uses carry-in 1.
  - Registers the selected 4-bit slice and carry-out.
- Bits above the current segment are carried down the pipeline in skew registers, alongside the valid bit.
- Latency: exactly SEG cycles from input transfer to o_valid, with i_ready held 1. Throughput is 1 per cycle.
- Flags:
  - o_borrow = ~(final carry-out).
  - o_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), using A[MSB] and B[MSB] carried through the pipeline.
- o_diff, o_borrow and o_ovf are registered and stable while o_valid=1 && i_ready=0.
- Boundary cases:
  - A=B gives diff 0, borrow 0.
  - 0 - 1 gives all-ones, borrow 1.
  - A = most-negative, B=1 gives ovf 1.
- Input accepted in the same cycle as an output is drained: legal, with no stall.
- Reset asserted mid-operation: all in-flight results are discarded and o_valid drops immediately (async).

Optional Feature:
- Macro CSA_SUB_SAT_EN.
- Defined: when o_ovf would be 1, o_diff is clamped to the signed limit.
  - A[MSB]=0 gives 0111..1 (the largest positive value).
  - A[MSB]=1 gives 1000..0 (the most negative value).
- With CSA_SUB_SAT_EN defined, o_ovf and o_borrow still report the raw condition, and latency is unchanged.
- Not defined: o_diff is the wrapped modulo result.

Test Plan:
- Reset, then a single op 0x9C4 - 0x1A7, i_ready=1 -> o_valid exactly 3 cycles later; o_diff=0x81D, o_borrow=0, o_ovf=0.
- 0x000 - 0x001 -> o_diff=0xFFF, o_borrow=1, o_ovf=0. Then 0x800 - 0x001 -> o_diff=0x7FF, o_ovf=1, o_borrow=0. With CSA_SUB_SAT_EN defined -> o_diff=0x800.
- Back-to-back stream of 20 random pairs, i_valid=1 and i_ready=1 every cycle -> 20 results in order, one per cycle, matching a reference model, each 3 cycles after its input.
- Drive i_ready=0 for 5 cycles while 3 ops are in flight -> o_ready=0, o_diff stable, no loss. On release, results drain in order with no duplicates.
- Assert i_rst_n=0 for 1 cycle with 2 ops in flight -> o_valid=0 immediately; no stale results appear afterwards. The next op completes with 3-cycle latency.
- 0x7FF - 0x800 -> o_diff=0xFFF, o_ovf=1, o_borrow=1. With CSA_SUB_SAT_EN defined -> o_diff=0x7FF.
